// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: captures decoded control and register-file read data,
// resolves EX/MEM forwarding per operand, detects load-use hazards and keeps a
// saturating stall counter for debug.

// Per-operand forwarding mux: picks EX result, then MEM result, then regfile data.
module id_ex_fwd #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int REG0_IDX = 0,
    parameter int PC_IDX   = 15,
    parameter int T_IDX    = 14
) (
    input  logic [AW-1:0] src_idx,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_ok,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_ok,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] fwd_data
);
    localparam logic [AW-1:0] REG0 = AW'(REG0_IDX);
    localparam logic [AW-1:0] PC   = AW'(PC_IDX);
    localparam logic [AW-1:0] T    = AW'(T_IDX);

    // The regfile stores (data==0) into T, so a forwarded T value must match.
    function automatic logic [DW-1:0] t_xform(input logic [AW-1:0] rd,
                                              input logic [DW-1:0] data);
        if (rd == T) return {{(DW-1){1'b0}}, (data == '0)};
        return data;
    endfunction

    // REG0/PC reads always come straight from the regfile; EX beats MEM.
    always_comb begin
        fwd_data = rf_data;
        if (src_idx != REG0 && src_idx != PC) begin
            if (ex_ok && ex_rd == src_idx)
                fwd_data = t_xform(ex_rd, ex_data);
            else if (mem_ok && mem_rd == src_idx)
                fwd_data = t_xform(mem_rd, mem_data);
        end
    end
endmodule

module id_ex_stage #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwre,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_use_imm,
    input  logic [3:0]    id_aluop,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic          ex_fwd_regwre,
    input  logic          ex_fwd_memread,
    input  logic [AW-1:0] ex_fwd_rd,
    input  logic [DW-1:0] ex_fwd_data,
    input  logic          mem_fwd_regwre,
    input  logic [AW-1:0] mem_fwd_rd,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          hold_in,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic          ex_regwre,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic [3:0]    ex_aluop,
    output logic [AW-1:0] ex_rd,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [DW-1:0] ex_op_a,
    output logic [DW-1:0] ex_op_b,
    output logic [DW-1:0] ex_store_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic [15:0]   stall_count
);
    // Register indices shared with the regfile configuration.
    localparam int REG0_IDX = 0;
    localparam int PC_IDX   = 15;
    localparam int T_IDX    = 14;
    localparam logic [AW-1:0] REG0 = AW'(REG0_IDX);
    localparam logic [AW-1:0] PC   = AW'(PC_IDX);

    typedef struct packed {
        logic          valid;
        logic          regwre;
        logic          memread;
        logic          memwrite;
        logic [3:0]    aluop;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [DW-1:0] op_a;
        logic [DW-1:0] op_b;
        logic [DW-1:0] store;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } ex_regs_t;

    ex_regs_t ex_d, ex_q;
    logic [15:0] stall_count_d, stall_count_q;

    logic ex_dst_ok, mem_dst_ok, ex_fwd_ok, mem_fwd_ok, hazard;
    logic [1:0][AW-1:0] src_idx;
    logic [1:0][DW-1:0] src_rf;
    logic [1:0][DW-1:0] src_fwd;

    // Source qualification and load-use detection; a load in EX cannot forward.
    always_comb begin
        ex_dst_ok  = ex_fwd_regwre && ex_fwd_rd != REG0 && ex_fwd_rd != PC;
        mem_dst_ok = mem_fwd_regwre && mem_fwd_rd != REG0 && mem_fwd_rd != PC;
        ex_fwd_ok  = ex_dst_ok && !ex_fwd_memread;
        mem_fwd_ok = mem_dst_ok;
        // rt compared even for immediate forms: cheaper than decoding use.
        hazard = id_valid && ex_dst_ok && ex_fwd_memread &&
                 (ex_fwd_rd == id_rs || ex_fwd_rd == id_rt);
        stall  = !Rst && (hold_in || (hazard && !flush));
    end

    assign src_idx = {id_rt, id_rs};
    assign src_rf  = {rd2, rd1};

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        id_ex_fwd #(
            .DW(DW), .AW(AW),
            .REG0_IDX(REG0_IDX), .PC_IDX(PC_IDX), .T_IDX(T_IDX)
        ) u_fwd (
            .src_idx  (src_idx[g]),
            .rf_data  (src_rf[g]),
            .ex_ok    (ex_fwd_ok),
            .ex_rd    (ex_fwd_rd),
            .ex_data  (ex_fwd_data),
            .mem_ok   (mem_fwd_ok),
            .mem_rd   (mem_fwd_rd),
            .mem_data (mem_fwd_data),
            .fwd_data (src_fwd[g])
        );
    end

    // Next-state for the EX registers: hold > flush > hazard bubble > capture.
    always_comb begin
        ex_d = ex_q;
        if (hold_in) begin
            ex_d = ex_q;
        end else if (flush || hazard) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = id_valid;
            ex_d.regwre   = id_regwre && id_valid;
            ex_d.memread  = id_memread && id_valid;
            ex_d.memwrite = id_memwrite && id_valid;
            ex_d.aluop    = id_aluop;
            ex_d.rd       = id_rd;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.op_a     = src_fwd[0];
            ex_d.op_b     = id_use_imm ? id_imm : src_fwd[1];
            ex_d.store    = src_fwd[1];
            ex_d.imm      = id_imm;
            ex_d.pc       = id_pc;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    // Pipeline register and counter state.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_regwre     = ex_q.regwre;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_aluop      = ex_q.aluop;
    assign ex_rd         = ex_q.rd;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_op_a       = ex_q.op_a;
    assign ex_op_b       = ex_q.op_b;
    assign ex_store_data = ex_q.store;
    assign ex_imm        = ex_q.imm;
    assign ex_pc         = ex_q.pc;
    assign stall_count   = stall_count_q;
endmodule
